// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} icache_state_t;

    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_WORDS = 4;

    function automatic int ob_f(input int words);
        return $clog2(words);
    endfunction

    function automatic int ib_f(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tagw_f(input int sets, input int words);
        return 32 - 2 - $clog2(sets) - $clog2(words);
    endfunction

    localparam int OB   = ob_f(ICACHE_WORDS);
    localparam int IB   = ib_f(ICACHE_SETS);
    localparam int TAGW = tagw_f(ICACHE_SETS, ICACHE_WORDS);

endpackage

// File: rtl/icache_array.sv
// Tag, valid and data storage: combinational read, one word write, tag/valid write, clear-all.
module icache_array
    import icache_pkg::*;
#(
    parameter  int SETS  = ICACHE_SETS,
    parameter  int WORDS = ICACHE_WORDS,
    localparam int AOB   = ob_f(WORDS),
    localparam int AIB   = ib_f(SETS),
    localparam int ATW   = tagw_f(SETS, WORDS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AIB-1:0]  rd_idx_i,
    input  logic [AOB-1:0]  rd_off_i,
    output logic [ATW-1:0]  rd_tag_o,
    output logic            rd_valid_o,
    output logic [31:0]     rd_word_o,
    input  logic            wr_en_i,
    input  logic [AIB-1:0]  wr_idx_i,
    input  logic [AOB-1:0]  wr_off_i,
    input  logic [31:0]     wr_data_i,
    input  logic            tv_en_i,
    input  logic [AIB-1:0]  tv_idx_i,
    input  logic [ATW-1:0]  tv_tag_i,
    input  logic            tv_valid_i,
    input  logic            clr_all_i
);

    logic [SETS-1:0] valid_q;
    logic [ATW-1:0]  tag_q  [SETS];
    logic [31:0]     data_q [SETS][WORDS];

    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_word_o  = data_q[rd_idx_i][rd_off_i];

    // Clear-all wins over a same-cycle per-line valid write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (clr_all_i) begin
            valid_q <= '0;
        end else if (tv_en_i) begin
            valid_q[tv_idx_i] <= tv_valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (tv_en_i) begin
            tag_q[tv_idx_i] <= tv_tag_i;
        end
        if (wr_en_i) begin
            data_q[wr_idx_i][wr_off_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: combinational hit path, word-serial line fill on miss.
module icache
    import icache_pkg::*;
#(
    parameter int SETS  = ICACHE_SETS,
    parameter int WORDS = ICACHE_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_req,
    input  logic [31:0] pc_adr,
    output logic [31:0] instr,
    output logic        hit,
    output logic        stall,
    input  logic        flush,
    output logic        mem_instrreq,
    output logic [31:0] mem_instradr,
    input  logic        mem_abort,
    input  logic [31:0] mem_instr
);

    localparam int LOB  = ob_f(WORDS);
    localparam int LIB  = ib_f(SETS);
    localparam int LTW  = tagw_f(SETS, WORDS);
    localparam int LW   = LTW + LIB;

    icache_state_t  state_q, state_d;
    logic [LOB-1:0] cnt_q, cnt_d;
    logic [LW-1:0]  line_q, line_d;

    logic [LIB-1:0] pc_idx;
    logic [LOB-1:0] pc_off;
    logic [LTW-1:0] pc_tag;
    logic [LTW-1:0] rd_tag;
    logic           rd_valid;
    logic [31:0]    rd_word;
    logic           idle, miss;
    logic           wr_en, tv_en, tv_valid;
    logic [LIB-1:0] tv_idx;
    logic           unused_adr;

    assign unused_adr = ^pc_adr[1:0];
    assign pc_off     = pc_adr[2 +: LOB];
    assign pc_idx     = pc_adr[2+LOB +: LIB];
    assign pc_tag     = pc_adr[31 -: LTW];

    assign idle  = (state_q == IDLE);
    assign hit   = idle && pc_req && rd_valid && (rd_tag == pc_tag);
    assign miss  = idle && pc_req && !hit;
    assign instr = hit ? rd_word : 32'h0;
    assign stall = (pc_req && !hit) || !idle;

    // Address is a pure function of the latched line and counter, so it stays put from REQ to capture.
    assign mem_instrreq = (state_q == REQ);
    assign mem_instradr = {line_q, cnt_q, 2'b00};

    // The miss-time valid clear targets the fetch index; completion targets the latched line.
    assign tv_idx = idle ? pc_idx : line_q[LIB-1:0];

    icache_array #(.SETS(SETS), .WORDS(WORDS)) u_array (
        .clk        (clk),
        .reset      (reset),
        .rd_idx_i   (pc_idx),
        .rd_off_i   (pc_off),
        .rd_tag_o   (rd_tag),
        .rd_valid_o (rd_valid),
        .rd_word_o  (rd_word),
        .wr_en_i    (wr_en),
        .wr_idx_i   (line_q[LIB-1:0]),
        .wr_off_i   (cnt_q),
        .wr_data_i  (mem_instr),
        .tv_en_i    (tv_en),
        .tv_idx_i   (tv_idx),
        .tv_tag_i   (line_q[LW-1 -: LTW]),
        .tv_valid_i (tv_valid),
        .clr_all_i  (flush)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        line_d   = line_q;
        wr_en    = 1'b0;
        tv_en    = 1'b0;
        tv_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss) begin
                    line_d  = pc_adr[31 -: LW];
                    cnt_d   = '0;
                    tv_en   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: state_d = WAIT;
            WAIT: begin
                if (!mem_abort) begin
                    wr_en = 1'b1;
                    if (cnt_q == LOB'(WORDS - 1)) begin
                        tv_en    = 1'b1;
                        tv_valid = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = REQ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Flush drops any fill in flight, including one completing this cycle.
        if (flush) begin
            state_d = IDLE;
            wr_en   = 1'b0;
            tv_en   = 1'b0;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: stimulus pushes expected instructions and memory addresses,
// a negedge monitor pops and compares them whenever the DUT hits or requests memory.
module tb_icache;

    logic        clk;
    logic        reset;
    logic        pc_req;
    logic [31:0] pc_adr;
    logic [31:0] instr;
    logic        hit;
    logic        stall;
    logic        flush;
    logic        mem_instrreq;
    logic [31:0] mem_instradr;
    logic        mem_abort;
    logic [31:0] mem_instr;

    int n_checks = 0;
    int n_fail   = 0;
    int abt_cnt  = 0;
    logic prev_req = 1'b0;

    logic [31:0] exp_q[$];
    logic [31:0] adr_q[$];

    icache #(.SETS(16), .WORDS(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_req       (pc_req),
        .pc_adr       (pc_adr),
        .instr        (instr),
        .hit          (hit),
        .stall        (stall),
        .flush        (flush),
        .mem_instrreq (mem_instrreq),
        .mem_instradr (mem_instradr),
        .mem_abort    (mem_abort),
        .mem_instr    (mem_instr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: word at address a is 0x1000_0000 + a/4 - 0x10; busy for four edges after a request.
    assign mem_instr = 32'h1000_0000 + (mem_instradr >> 2) - 32'h10;
    assign mem_abort = (abt_cnt != 0);

    always @(posedge clk) begin
        if (mem_instrreq) abt_cnt <= 4;
        else if (abt_cnt != 0) abt_cnt <= abt_cnt - 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (hit) begin
            if (exp_q.size() == 0) chk("unexpected_hit", 32'd1, 32'd0);
            else chk("instr", instr, exp_q.pop_front());
        end else begin
            chk("instr_zero_on_miss", instr, 32'h0);
        end
        if (mem_instrreq) begin
            if (adr_q.size() == 0) chk("unexpected_memreq", mem_instradr, 32'hFFFF_FFFF);
            else chk("mem_adr", mem_instradr, adr_q.pop_front());
            chk("req_single_pulse", {31'd0, prev_req}, 32'd0);
        end
        prev_req <= mem_instrreq;
    end

    task automatic push_line(input logic [31:0] base);
        for (int k = 0; k < 4; k++) adr_q.push_back(base + 32'(4 * k));
    endtask

    // Called just after a rising edge; returns just after the edge following the hit.
    task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input int exp_stall);
        int  st = 0;
        bit  got = 0;
        pc_req = 1'b1;
        pc_adr = a;
        exp_q.push_back(exp);
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            if (hit) got = 1;
            else if (stall) st++;
        end
        chk("fetch_completes", {31'd0, got}, 32'd1);
        chk("stall_cycles", 32'(st), 32'(exp_stall));
        @(posedge clk);
        #1 pc_req = 1'b0;
    endtask

    initial begin
        reset  = 1'b0;
        pc_req = 1'b0;
        pc_adr = 32'h0;
        flush  = 1'b0;
        #2 reset = 1'b1;

        @(negedge clk);
        chk("rst_instr", instr, 32'h0);
        chk("rst_hit", {31'd0, hit}, 32'd0);
        chk("rst_memreq", {31'd0, mem_instrreq}, 32'd0);
        chk("rst_memadr", mem_instradr, 32'h0);
        chk("rst_stall_noreq", {31'd0, stall}, 32'd0);
        pc_req = 1'b1;
        pc_adr = 32'h40;
        #1 chk("rst_stall_req", {31'd0, stall}, 32'd1);
        pc_req = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_stall", {31'd0, stall}, 32'd0);
        end
        @(posedge clk);
        #1;

        push_line(32'h40);
        fetch(32'h40, 32'h1000_0000, 25);

        for (int k = 1; k < 4; k++) begin
            pc_req = 1'b1;
            pc_adr = 32'h40 + 32'(4 * k);
            exp_q.push_back(32'h1000_0000 + 32'(k));
            @(negedge clk);
            chk("seq_hit", {31'd0, hit}, 32'd1);
            chk("seq_stall", {31'd0, stall}, 32'd0);
            @(posedge clk);
            #1;
        end
        pc_req = 1'b0;

        push_line(32'h140);
        fetch(32'h140, 32'h1000_0040, 25);
        push_line(32'h40);
        fetch(32'h40, 32'h1000_0000, 25);

        // Flush during the second WAIT cycle of word 1 (cycle 9 of the fill).
        adr_q.push_back(32'h80);
        adr_q.push_back(32'h84);
        pc_req = 1'b1;
        pc_adr = 32'h80;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        pc_req = 1'b0;
        @(negedge clk);
        chk("flush_idle_stall", {31'd0, stall}, 32'd0);
        chk("flush_no_req", {31'd0, mem_instrreq}, 32'd0);
        @(posedge clk);
        #1;
        push_line(32'h80);
        fetch(32'h80, 32'h1000_0010, 25);
        push_line(32'h40);
        fetch(32'h40, 32'h1000_0000, 25);
        fetch(32'h80, 32'h1000_0010, 0);

        // Reset asserted in the middle of the REQ cycle of a new fill.
        pc_req = 1'b1;
        pc_adr = 32'h100;
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk("rst_mid_memreq", {31'd0, mem_instrreq}, 32'd0);
        chk("rst_mid_stall_req", {31'd0, stall}, 32'd1);
        pc_req = 1'b0;
        #1 chk("rst_mid_stall_noreq", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        push_line(32'h80);
        fetch(32'h80, 32'h1000_0010, 25);

        repeat (3) @(negedge clk);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("adr_q_drained", 32'(adr_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
